// File: rtl/crem_sync_pkg.sv
// Shared constants for the handshake data synchroniser.
//   EN_LEVEL / EN_TOGGLE : encodings for the enable mode parameter
//   MIN_SYNC_STAGES      : smallest synchroniser depth considered metastability-safe
package crem_sync_pkg;

    localparam int unsigned EN_LEVEL        = 0;
    localparam int unsigned EN_TOGGLE       = 1;
    localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser.
// Ports:
//   clk : destination clock
//   rst : synchronous active-low reset, clears every stage
//   d   : asynchronous input bit
//   q   : synchronised output (last stage)
module sync_chain
    import crem_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_depth
        $error("sync_chain: NUM_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end

    logic [NUM_STAGES-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[NUM_STAGES-2:0], d};
        end
    end

    assign q = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_hs.sv
// Multi-bit bus synchroniser with valid/ack handshake and overrun accounting.
// Only bus_enable crosses through a synchroniser; unsync_bus is sampled when the
// synchronised enable produces an event, relying on the source holding it stable.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-low reset
//   unsync_bus   : asynchronous data word
//   bus_enable   : asynchronous enable (level: rising edge; toggle: any change)
//   sync_ack     : consumer has taken sync_bus
//   ovr_clr      : clears overrun and drop_cnt
//   sync_bus     : captured data, stable between accepted events
//   enable_pulse : one-cycle strobe when sync_bus is loaded
//   sync_valid   : data held, awaiting ack
//   overrun      : sticky, an event arrived while data was still unacknowledged
//   drop_cnt     : saturating overrun event counter
module data_sync_hs
    import crem_sync_pkg::*;
#(
    parameter int unsigned           BUS_WIDTH  = 8,
    parameter int unsigned           NUM_STAGES = 2,
    parameter int unsigned           EN_MODE    = 0,
    parameter int unsigned           OVERWRITE  = 0,
    parameter int unsigned           CNT_W      = 4,
    parameter logic [BUS_WIDTH-1:0]  RST_VAL    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    input  logic                 sync_ack,
    input  logic                 ovr_clr,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse,
    output logic                 sync_valid,
    output logic                 overrun,
    output logic [CNT_W-1:0]     drop_cnt
);

    if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_depth
        $error("data_sync_hs: NUM_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
    if (EN_MODE > EN_TOGGLE) begin : g_bad_mode
        $error("data_sync_hs: EN_MODE must be 0 (level) or 1 (toggle)");
    end
    if (OVERWRITE > 1) begin : g_bad_ovw
        $error("data_sync_hs: OVERWRITE must be 0 or 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("data_sync_hs: CNT_W must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 en_sync;
    logic                 prev_q;
    logic                 evt;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 pulse_q, pulse_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    sync_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_en_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus_enable),
        .q   (en_sync)
    );

    // prev resets to 0 like the chain, so reset release never creates an event.
    assign evt = (EN_MODE == EN_TOGGLE) ? (en_sync ^ prev_q) : (en_sync & ~prev_q);

    always_comb begin
        bus_d   = bus_q;
        pulse_d = 1'b0;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;

        if (ovr_clr) begin
            ovr_d = 1'b0;
            cnt_d = '0;
        end

        if (evt) begin
            if (!valid_q || sync_ack) begin
                // Ack in the same cycle frees the slot for the new word.
                bus_d   = unsync_bus;
                pulse_d = 1'b1;
                valid_d = 1'b1;
            end else begin
                // Overrun is applied after the clear, so a coincident set wins.
                ovr_d = 1'b1;
                if (cnt_d != CNT_MAX) begin
                    cnt_d = cnt_d + CNT_W'(1);
                end
                if (OVERWRITE != 0) begin
                    bus_d   = unsync_bus;
                    pulse_d = 1'b1;
                end
            end
        end else if (sync_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q  <= 1'b0;
            bus_q   <= RST_VAL;
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= en_sync;
            bus_q   <= bus_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_bus     = bus_q;
    assign enable_pulse = pulse_q;
    assign sync_valid   = valid_q;
    assign overrun      = ovr_q;
    assign drop_cnt     = cnt_q;

endmodule

// File: tb/tb_data_sync_hs.sv
// Directed bench for data_sync_hs: level mode keep/overwrite pair sharing one
// stimulus, plus a 3-stage toggle-mode instance. Accepted words are queued when
// driven and popped whenever the matching DUT strobes enable_pulse.
module tb_data_sync_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] bus_a = '0, bus_t = '0;
    logic       en_a = 1'b0, en_t = 1'b0;
    logic       ack_a = 1'b0, ack_t = 1'b0;
    logic       clr_a = 1'b0, clr_t = 1'b0;

    logic [7:0] l_bus, w_bus, t_bus;
    logic       l_pulse, w_pulse, t_pulse;
    logic       l_valid, w_valid, t_valid;
    logic       l_ovr, w_ovr, t_ovr;
    logic [3:0] l_cnt, w_cnt, t_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] q_l[$];
    logic [7:0] q_w[$];
    logic [7:0] q_t[$];

    always #5 clk = ~clk;

    data_sync_hs #(
        .BUS_WIDTH(8), .NUM_STAGES(2), .EN_MODE(0), .OVERWRITE(0), .CNT_W(4), .RST_VAL(8'h00)
    ) dut_lvl (
        .clk(clk), .rst(rst), .unsync_bus(bus_a), .bus_enable(en_a), .sync_ack(ack_a),
        .ovr_clr(clr_a), .sync_bus(l_bus), .enable_pulse(l_pulse), .sync_valid(l_valid),
        .overrun(l_ovr), .drop_cnt(l_cnt)
    );

    data_sync_hs #(
        .BUS_WIDTH(8), .NUM_STAGES(2), .EN_MODE(0), .OVERWRITE(1), .CNT_W(4), .RST_VAL(8'h00)
    ) dut_ovw (
        .clk(clk), .rst(rst), .unsync_bus(bus_a), .bus_enable(en_a), .sync_ack(ack_a),
        .ovr_clr(clr_a), .sync_bus(w_bus), .enable_pulse(w_pulse), .sync_valid(w_valid),
        .overrun(w_ovr), .drop_cnt(w_cnt)
    );

    data_sync_hs #(
        .BUS_WIDTH(8), .NUM_STAGES(3), .EN_MODE(1), .OVERWRITE(0), .CNT_W(4), .RST_VAL(8'h00)
    ) dut_tgl (
        .clk(clk), .rst(rst), .unsync_bus(bus_t), .bus_enable(en_t), .sync_ack(ack_t),
        .ovr_clr(clr_t), .sync_bus(t_bus), .enable_pulse(t_pulse), .sync_valid(t_valid),
        .overrun(t_ovr), .drop_cnt(t_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_l"}, {l_bus, l_pulse, l_valid, l_ovr, l_cnt}, 32'h0);
        chk({tag, "_w"}, {w_bus, w_pulse, w_valid, w_ovr, w_cnt}, 32'h0);
        chk({tag, "_t"}, {t_bus, t_pulse, t_valid, t_ovr, t_cnt}, 32'h0);
    endtask

    // Scoreboard: every strobe must match the oldest queued word.
    always @(negedge clk) begin
        if (l_pulse === 1'b1) begin
            if (q_l.size() == 0) chk("lvl_unexpected_pulse", 1, 0);
            else chk("lvl_sb_data", l_bus, q_l.pop_front());
        end
        if (w_pulse === 1'b1) begin
            if (q_w.size() == 0) chk("ovw_unexpected_pulse", 1, 0);
            else chk("ovw_sb_data", w_bus, q_w.pop_front());
        end
        if (t_pulse === 1'b1) begin
            if (q_t.size() == 0) chk("tgl_unexpected_pulse", 1, 0);
            else chk("tgl_sb_data", t_bus, q_t.pop_front());
        end
    end

    initial begin
        // Reset for three edges.
        ticks(3);
        chk_reset_state("reset");
        rst = 1'b1;

        // Latency: first sampling edge E1, load at E3.
        bus_a = 8'hA5; en_a = 1'b1;
        q_l.push_back(8'hA5); q_w.push_back(8'hA5);
        tick();
        chk("lat_e1", {l_pulse, l_bus}, {1'b0, 8'h00});
        tick();
        chk("lat_e2", {l_pulse, l_bus}, {1'b0, 8'h00});
        tick();
        chk("lat_e3_l", {l_pulse, l_valid, l_bus}, {1'b1, 1'b1, 8'hA5});
        chk("lat_e3_w", {w_pulse, w_valid, w_bus}, {1'b1, 1'b1, 8'hA5});
        tick();
        chk("lat_one_cycle", l_pulse, 1'b0);

        // Ack coincident with a new event.
        en_a = 1'b0; ticks(3);
        bus_a = 8'h3C; en_a = 1'b1;
        q_l.push_back(8'h3C); q_w.push_back(8'h3C);
        ticks(2);
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        chk("ackevt_l", {l_pulse, l_valid, l_ovr, l_bus}, {1'b1, 1'b1, 1'b0, 8'h3C});
        chk("ackevt_w", {w_pulse, w_valid, w_ovr, w_bus}, {1'b1, 1'b1, 1'b0, 8'h3C});

        // Overrun: keep drops the word, overwrite loads it.
        en_a = 1'b0; ticks(3);
        bus_a = 8'h77; en_a = 1'b1;
        q_w.push_back(8'h77);
        ticks(3);
        chk("ovr_keep", {l_pulse, l_ovr, l_cnt, l_bus}, {1'b0, 1'b1, 4'd1, 8'h3C});
        chk("ovr_write", {w_pulse, w_ovr, w_cnt, w_bus}, {1'b1, 1'b1, 4'd1, 8'h77});

        // 19 more overruns: 20 in total saturates a 4-bit counter at 15.
        for (int i = 0; i < 19; i++) begin
            en_a = 1'b0; ticks(3);
            bus_a = 8'h80 + 8'(i); en_a = 1'b1;
            q_w.push_back(8'h80 + 8'(i));
            ticks(3);
        end
        chk("sat_keep", {l_cnt, l_ovr, l_valid, l_bus}, {4'd15, 1'b1, 1'b1, 8'h3C});
        chk("sat_write", {w_cnt, w_ovr, w_bus}, {4'd15, 1'b1, 8'h92});

        // Clear coincident with an overrun: set wins, count restarts at 1.
        en_a = 1'b0; ticks(3);
        bus_a = 8'h55; en_a = 1'b1;
        q_w.push_back(8'h55);
        ticks(2);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("clr_set_l", {l_ovr, l_cnt, l_bus}, {1'b1, 4'd1, 8'h3C});
        chk("clr_set_w", {w_ovr, w_cnt, w_bus}, {1'b1, 4'd1, 8'h55});
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("clr_only_l", {l_ovr, l_cnt}, {1'b0, 4'd0});
        chk("clr_only_w", {w_ovr, w_cnt}, {1'b0, 4'd0});

        // Ack drops valid; a further ack with valid low changes nothing.
        ack_a = 1'b1;
        tick();
        chk("ack_l", {l_valid, l_bus}, {1'b0, 8'h3C});
        chk("ack_w", {w_valid, w_bus}, {1'b0, 8'h55});
        tick();
        ack_a = 1'b0;
        chk("ack_idle_l", {l_valid, l_pulse, l_bus}, {1'b0, 1'b0, 8'h3C});

        // Toggle mode, 3 stages: load on the fourth edge.
        bus_t = 8'h11; en_t = 1'b1;
        q_t.push_back(8'h11);
        ticks(3);
        chk("tgl_rise_e3", t_pulse, 1'b0);
        tick();
        chk("tgl_rise_e4", {t_pulse, t_valid, t_bus}, {1'b1, 1'b1, 8'h11});
        ack_t = 1'b1; tick(); ack_t = 1'b0;
        chk("tgl_ack", t_valid, 1'b0);
        bus_t = 8'h22; en_t = 1'b0;
        q_t.push_back(8'h22);
        ticks(3);
        chk("tgl_fall_e3", t_pulse, 1'b0);
        tick();
        chk("tgl_fall_e4", {t_pulse, t_valid, t_bus}, {1'b1, 1'b1, 8'h22});

        // Back-to-back toggles one cycle apart, ack held: two adjacent events.
        ack_t = 1'b1;
        tick();
        chk("tgl_ack2", t_valid, 1'b0);
        bus_t = 8'h33; en_t = 1'b1;
        q_t.push_back(8'h33); q_t.push_back(8'h33);
        tick();
        en_t = 1'b0;
        ticks(2);
        chk("b2b_e3", t_pulse, 1'b0);
        tick();
        chk("b2b_e4", {t_pulse, t_bus}, {1'b1, 8'h33});
        tick();
        chk("b2b_e5", {t_pulse, t_ovr, t_cnt}, {1'b1, 1'b0, 4'd0});
        tick();
        ack_t = 1'b0;
        chk("b2b_done", {t_pulse, t_valid}, {1'b0, 1'b0});

        // Reset mid-transfer discards the in-flight toggle.
        en_a = 1'b0; ticks(3);
        en_t = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        en_t = 1'b0;
        ticks(2);
        rst = 1'b1;
        ticks(6);
        chk_reset_state("mid_reset");

        chk("sb_empty_l", q_l.size(), 0);
        chk("sb_empty_w", q_w.size(), 0);
        chk("sb_empty_t", q_t.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
